branch_resolve_unit: RTL and testbench

- AGEX-side counterpart of the branch predictor. It tracks predictions issued at decode, checks each one against the actual branch outcome from AGEX, and sends training updates back to the predictor.
- Holds an in-order FIFO of in-flight predictions. On each resolution it emits one registered update packet toward BP.
- On a misprediction it emits a one-cycle redirect pulse and squashes all younger in-flight entries.

---
 rtl/branch_resolve_unit.sv | 96 +++++++++
 tb/tb_branch_resolve_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: tracks in-flight branch predictions, resolves them in order
// against AGEX outcomes, trains the predictor and redirects fetch on a mispredict.
module branch_resolve_unit #(
    parameter int DBITS  = 32,
    parameter int BPBITS = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DBITS-1:0]         push_pc,
    input  logic [BPBITS-1:0]        push_idx,
    input  logic                     push_taken,
    input  logic [DBITS-1:0]         push_target,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [DBITS-1:0]         res_target,
    output logic                     upd_valid,
    output logic                     upd_dir,
    output logic [BPBITS-1:0]        upd_idx,
    output logic [DBITS-1:0]         upd_pc,
    output logic [DBITS-1:0]         upd_target,
    output logic                     redirect_valid,
    output logic [DBITS-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     resolve_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DBITS-1:0]  pc_q     [DEPTH];
    logic [BPBITS-1:0] idx_q    [DEPTH];
    logic              taken_q  [DEPTH];
    logic [DBITS-1:0]  target_q [DEPTH];
    logic [AW-1:0]     head, tail;
    logic              res_acc, mispredict, push_acc;
    logic [DBITS-1:0]  correct_pc;

    assign push_ready = count != FULL;
    assign res_acc    = res_valid && count != '0;
    assign mispredict = res_acc && (taken_q[head] != res_taken ||
                                    (res_taken && target_q[head] != res_target));
    assign correct_pc = res_taken ? res_target : pc_q[head] + DBITS'(4);
    // A mispredict flushes everything younger, including a branch arriving this cycle.
    assign push_acc   = push_valid && push_ready && !mispredict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_dir        <= 1'b0;
            upd_idx        <= '0;
            upd_pc         <= '0;
            upd_target     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            resolve_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                idx_q[i]    <= '0;
                taken_q[i]  <= 1'b0;
                target_q[i] <= '0;
            end
        end else begin
            upd_valid      <= res_acc;
            redirect_valid <= mispredict;
            if (res_valid && count == '0)
                resolve_err <= 1'b1;
            if (res_acc) begin
                upd_dir    <= res_taken;
                upd_idx    <= idx_q[head];
                upd_pc     <= pc_q[head];
                upd_target <= res_target;
            end
            if (mispredict) begin
                redirect_pc <= correct_pc;
                head        <= tail;
                count       <= '0;
            end else begin
                if (push_acc) begin
                    pc_q[tail]     <= push_pc;
                    idx_q[tail]    <= push_idx;
                    taken_q[tail]  <= push_taken;
                    target_q[tail] <= push_target;
                    tail           <= tail + AW'(1);
                end
                if (res_acc)
                    head <= head + AW'(1);
                count <= count + (AW+1)'(push_acc) - (AW+1)'(res_acc);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed table, corner sequences and random traffic
// checked against a queue-based model of the prediction FIFO.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic        clk = 0, reset = 1;
    logic        push_valid = 0, push_ready, push_taken = 0;
    logic [31:0] push_pc = 0, push_target = 0;
    logic [7:0]  push_idx = 0;
    logic        res_valid = 0, res_taken = 0;
    logic [31:0] res_target = 0;
    logic        upd_valid, upd_dir, redirect_valid, resolve_err;
    logic [7:0]  upd_idx;
    logic [31:0] upd_pc, upd_target, redirect_pc;
    logic [2:0]  count;

    branch_resolve_unit #(.DBITS(32), .BPBITS(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_idx(push_idx), .push_taken(push_taken), .push_target(push_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_dir(upd_dir), .upd_idx(upd_idx),
        .upd_pc(upd_pc), .upd_target(upd_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .resolve_err(resolve_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  idx;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [7:0]  idx;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        e_uv;
        logic        e_dir;
        logic [7:0]  e_idx;
        logic [31:0] e_pc;
        logic        e_rv;
        logic [31:0] e_rpc;
        int          e_cnt;
        logic        e_err;
    } vec_t;

    ent_t        q[$];
    vec_t        tbl[$];
    int          total = 0, bad = 0;
    logic        m_uv, m_dir, m_rv, m_err;
    logic [7:0]  m_idx;
    logic [31:0] m_pc, m_tgt, m_rpc;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        {m_uv, m_dir, m_rv, m_err} = '0;
        m_idx = 0; m_pc = 0; m_tgt = 0; m_rpc = 0;
    endfunction

    // One clock edge of the prediction FIFO, expressed as queue operations.
    function automatic void model_step();
        ent_t e;
        logic mis = 0;
        logic room = q.size() != DEPTH;
        m_uv = 0;
        m_rv = 0;
        if (res_valid) begin
            if (q.size() == 0) m_err = 1;
            else begin
                e = q.pop_front();
                m_uv = 1; m_dir = res_taken; m_idx = e.idx; m_pc = e.pc; m_tgt = res_target;
                mis = (e.taken != res_taken) || (res_taken && e.target != res_target);
                if (mis) begin
                    m_rv = 1;
                    m_rpc = res_taken ? res_target : e.pc + 32'd4;
                    q.delete();
                end
            end
        end
        if (push_valid && room && !mis)
            q.push_back('{pc: push_pc, idx: push_idx, taken: push_taken, target: push_target});
    endfunction

    function automatic void chk_model();
        chk("upd_valid", upd_valid, m_uv);
        chk("upd_dir", upd_dir, m_dir);
        chk("upd_idx", upd_idx, m_idx);
        chk("upd_pc", upd_pc, m_pc);
        chk("upd_target", upd_target, m_tgt);
        chk("redirect_valid", redirect_valid, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("count", count, q.size());
        chk("resolve_err", resolve_err, m_err);
    endfunction

    task automatic cycle(input logic pv, input logic [31:0] pc, input logic [7:0] idx,
                         input logic pt, input logic [31:0] ptg,
                         input logic rv, input logic rt, input logic [31:0] rtg);
        push_valid = pv; push_pc = pc; push_idx = idx; push_taken = pt; push_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        #1;
        chk("push_ready", push_ready, q.size() != DEPTH);
        @(posedge clk);
        model_step();
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        push_valid = 0; res_valid = 0;
        reset = 1;
        model_reset();
        #1;
        chk("rst_push_ready", push_ready, 1);
        chk_model();
        @(negedge clk);
        reset = 0;
    endtask

    function automatic vec_t mk(logic pv, logic [31:0] pc, logic [7:0] idx, logic pt,
                                logic [31:0] ptg, logic rv, logic rt, logic [31:0] rtg,
                                logic uv, logic dir, logic [7:0] uidx, logic [31:0] upc,
                                logic rdv, logic [31:0] rpc, int cnt, logic err);
        return '{pv, pc, idx, pt, ptg, rv, rt, rtg, uv, dir, uidx, upc, rdv, rpc, cnt, err};
    endfunction

    initial begin
        tbl.push_back(mk(1, 'h100, 'h40, 1, 'h200, 0, 0, 0,     0, 0, 'h00, 'h000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 1, 'h200,    1, 1, 'h40, 'h100, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h104, 'h41, 1, 'h300, 0, 0, 0,     0, 1, 'h40, 'h100, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0,        1, 0, 'h41, 'h104, 1, 'h108, 0, 0));
        tbl.push_back(mk(1, 'h110, 'h42, 1, 'h400, 0, 0, 0,     0, 0, 'h41, 'h104, 0, 0, 1, 0));
        tbl.push_back(mk(1, 'h114, 'h43, 1, 'h404, 0, 0, 0,     0, 0, 'h41, 'h104, 0, 0, 2, 0));
        tbl.push_back(mk(1, 'h118, 'h44, 1, 'h408, 0, 0, 0,     0, 0, 'h41, 'h104, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 1, 'h500,    1, 1, 'h42, 'h110, 1, 'h500, 0, 0));
        tbl.push_back(mk(1, 'hFFFF_FFFC, 'h45, 1, 'h10, 0, 0, 0, 0, 1, 'h42, 'h110, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0,        1, 0, 'h45, 'hFFFF_FFFC, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'hA0, 'h50, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 1, 0));
        tbl.push_back(mk(1, 'hA4, 'h51, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 2, 0));
        tbl.push_back(mk(1, 'hA8, 'h52, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 3, 0));
        tbl.push_back(mk(1, 'hAC, 'h53, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 4, 0));
        tbl.push_back(mk(1, 'hB0, 'h54, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 4, 0));
        tbl.push_back(mk(1, 'hB0, 'h54, 0, 0,   0, 0, 0,        0, 0, 'h45, 'hFFFF_FFFC, 0, 0, 4, 0));
        tbl.push_back(mk(1, 'hB0, 'h54, 0, 0,   1, 0, 0,        1, 0, 'h50, 'hA0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 'hB0, 'h54, 0, 0,   0, 0, 0,        0, 0, 'h50, 'hA0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0,        1, 0, 'h51, 'hA4, 0, 0, 3, 0));
        tbl.push_back(mk(1, 'hC0, 'h60, 0, 0,   1, 1, 'h900,    1, 1, 'h52, 'hA8, 1, 'h900, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,        0, 1, 'h52, 'hA8, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 1, 0,        0, 1, 'h52, 'hA8, 0, 0, 0, 1));

        model_reset();
        #12;
        chk("rst_push_ready", push_ready, 1);
        chk_model();
        reset = 0;

        foreach (tbl[i]) begin
            cycle(tbl[i].pv, tbl[i].pc, tbl[i].idx, tbl[i].pt, tbl[i].ptg,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtg);
            chk($sformatf("t%0d_upd_valid", i), upd_valid, tbl[i].e_uv);
            chk($sformatf("t%0d_upd_dir", i), upd_dir, tbl[i].e_dir);
            chk($sformatf("t%0d_upd_idx", i), upd_idx, tbl[i].e_idx);
            chk($sformatf("t%0d_upd_pc", i), upd_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_redirect_valid", i), redirect_valid, tbl[i].e_rv);
            if (tbl[i].e_rv)
                chk($sformatf("t%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
            chk($sformatf("t%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("t%0d_resolve_err", i), resolve_err, tbl[i].e_err);
        end

        // Reset arriving while an update and redirect are on the outputs.
        do_reset();
        cycle(1, 'h300, 'h70, 1, 'h600, 0, 0, 0);
        cycle(1, 'h304, 'h71, 1, 'h604, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_upd_valid", upd_valid, 1);
        chk("pre_rst_redirect_valid", redirect_valid, 1);
        reset = 1;
        #1;
        chk("async_rst_upd_valid", upd_valid, 0);
        chk("async_rst_redirect_valid", redirect_valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_upd_pc", upd_pc, 0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Ordering across several pointer wraps.
        for (int i = 0; i <= 10; i++) begin
            cycle(i < 10, 32'h1000 + 32'(4 * i), 8'(i), 0, 0, i > 0, 0, 0);
            if (i > 0) chk($sformatf("wrap_order_%0d", i), upd_pc, 32'h1000 + 32'(4 * (i - 1)));
        end
        chk("wrap_end_count", count, 0);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic rt;
            rt = 1'($urandom);
            cycle($urandom % 3 != 0, $urandom, 8'($urandom), ($urandom % 4 == 0) ? ~rt : rt,
                  32'($urandom_range(0, 3)) << 4, $urandom % 4 == 0, rt,
                  32'($urandom_range(0, 3)) << 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
